i3c_rx_word_packer: RTL
=======================

# i3c_rx_word_packer

Downstream consumer of the I3C read-register byte stream (`o_transfer`/`o_transfer_valid`/`o_transfer_last`). It packs received bytes into 32-bit words, tags each word with its valid byte count and end-of-transfer flag, and buffers words in a small first-word-fall-through FIFO toward the register-map / host read port. The upstream byte source has no backpressure, so this block absorbs bytes unconditionally and reports loss with a sticky overflow flag.

## Interface
- `FIFO_DEPTH`, default 8: word entries; power of two, ≥2.
- `i_clk` in 1: system clock (same domain as the byte source).
- `i_reset_n` in 1: one clock; reset is asynchronous and active-low.
- `i_transfer` in 8: received byte.
- `i_transfer_valid` in 1: byte strobe, one cycle per byte.
- `i_transfer_last` in 1: qualifies the final byte of a transfer.
- `i_clear` in 1: synchronous flush of packer, FIFO and overflow flag.
- `o_data` out 32: head word.
- `o_count` out 3: valid bytes in head word, 1..4.
- `o_last` out 1: head word closes a transfer.
- `o_valid` out 1: FIFO not empty.
- `i_ready` in 1: consumer accepts head word when `o_valid && i_ready`.
- `o_level` out $clog2(FIFO_DEPTH)+1: words stored.
- `o_overflow` out 1: sticky, a completed word was dropped.

## Operation
- Packer holds an assembly register (32 b) and lane index `lane` (0..3).
- Accepted byte (`i_transfer_valid`) writes lane `lane`; default mapping: lane k → bits [8k+7:8k].
- Word completes when the byte fills lane 3 or carries `i_transfer_last`. Completed word = assembly register merged with the current byte; unused lanes forced to 0; count = lane+1; last = `i_transfer_last`.
- On completion: push into FIFO, clear assembly register, `lane` ← 0. Otherwise `lane` ← lane+1.
- A byte with `i_transfer_last` at lane 3 produces one word, count 4, last 1; no empty trailing word.
- Push permitted when `o_level < FIFO_DEPTH`, or when FIFO is full and a pop occurs in the same cycle (push and pop both execute, level unchanged).
- Full, no pop, word completes: word discarded, `o_overflow` ← 1, packer still resets lane to 0; FIFO content unchanged.
- Pop: `o_valid && i_ready`; read pointer advances, level decrements. `i_ready` while empty: ignored.
- Pointers wrap modulo FIFO_DEPTH; level distinguishes full from empty.
- `i_clear`: pointers, level, lane, assembly register and `o_overflow` to 0 next edge; clear wins over a simultaneous byte or pop (both discarded).

## Timing
- Reset (async assert, sync-released by system): all state 0; `o_valid`=0, `o_level`=0, `o_overflow`=0, `o_data`=0, `o_count`=0, `o_last`=0.
- Latency: word pushed on the edge accepting its final byte; `o_valid`, `o_data`, `o_count`, `o_last` reflect it from that edge (FWFT, registered storage, no added read cycle when FIFO was empty).
- `o_data/o_count/o_last` are 0 while `o_valid`=0.
- Sustained rate: one byte per cycle in, one word per cycle out.
- `o_overflow` sets on the edge of the dropped push, holds until `i_clear` or reset.
- Reset mid-transfer: partial word lost; no word emitted for it.

## Configuration
- `I3C_RX_PACKER_BIG_ENDIAN_EN` undefined: lane k → bits [8k+7:8k] (first byte in LSB).
- Defined: lane k → bits [31-8k:24-8k] (first byte in MSB); partial words are left-justified, unused low lanes 0. Counts, last and flow control identical.

## Test plan
- Bytes 0x11,0x22,0x33,0x44 (last on 0x44), `i_ready`=1 → one word 0x44332211, count 4, last 1; with macro 0x11223344.
- Bytes 0xAA,0xBB (last on 0xBB) → 0x0000BBAA, count 2, last 1; with macro 0xAABB0000.
- 10 bytes 0x01..0x0A, last on 0x0A → words 0x04030201 (4,0), 0x08070605 (4,0), 0x00000A09 (2,1).
- DEPTH 8, `i_ready`=0, 36 bytes → `o_level`=8, 9th word dropped, `o_overflow`=1; drain yields the first 8 words in order; `i_clear` → `o_overflow`=0, `o_level`=0.
- Full FIFO with `i_ready`=1 on the cycle a word completes → push and pop both occur, level stays 8, `o_overflow` stays 0.
- Deassert `i_reset_n` after 2 bytes of a transfer, then send 0x5A with last → single word 0x0000005A, count 1; all outputs 0 during reset.

Source files
------------

// File: rtl/i3c_rx_word_packer.sv
// i3c_rx_word_packer: packs the I3C read-register byte stream into 32-bit words,
// each tagged with its valid byte count and an end-of-transfer flag, and buffers
// the words in a first-word-fall-through FIFO. The byte source has no
// backpressure, so a word that completes while the FIFO is full is dropped and
// the sticky o_overflow flag is set.
// Optional feature: define I3C_RX_PACKER_BIG_ENDIAN_EN to place the first byte in
// the MSB lane. Partial words are then left-justified.
module i3c_rx_word_packer #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [7:0]                    i_transfer,
    input  logic                          i_transfer_valid,
    input  logic                          i_transfer_last,
    input  logic                          i_clear,
    output logic [31:0]                   o_data,
    output logic [2:0]                    o_count,
    output logic                          o_last,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    // Position a byte in its lane of the 32-bit word.
    function automatic logic [31:0] lane_place(input logic [7:0] b, input logic [1:0] l);
`ifdef I3C_RX_PACKER_BIG_ENDIAN_EN
        lane_place = {b, 24'h000000} >> {l, 3'b000};
`else
        lane_place = {24'h000000, b} << {l, 3'b000};
`endif
    endfunction

    logic [31:0]   asm_q, asm_d;
    logic [1:0]    lane_q, lane_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;

    logic [31:0]   data_mem [FIFO_DEPTH];
    logic [2:0]    cnt_mem  [FIFO_DEPTH];
    logic          last_mem [FIFO_DEPTH];

    logic          pop;
    logic          full;
    logic          complete;
    logic          push;
    logic [31:0]   word;
    logic [2:0]    word_cnt;

    // Packer and FIFO control: completion, push/pop arbitration, next-state values.
    always_comb begin
        pop      = (level_q != '0) && i_ready;
        full     = (level_q == LW'(FIFO_DEPTH));
        complete = i_transfer_valid && ((lane_q == 2'd3) || i_transfer_last);
        // Assembly register only ever holds lanes below lane_q, so unused lanes stay 0.
        word     = asm_q | lane_place(i_transfer, lane_q);
        word_cnt = {1'b0, lane_q} + 3'd1;
        // A full FIFO still accepts the word when the head leaves in the same cycle.
        push     = complete && (!full || pop);

        asm_d    = asm_q;
        lane_d   = lane_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (i_clear) begin
            asm_d    = '0;
            lane_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (complete) begin
                asm_d  = '0;
                lane_d = '0;
            end else if (i_transfer_valid) begin
                asm_d  = word;
                lane_d = lane_q + 2'd1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LW'(1);
            end
            if (complete && !push) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            asm_q    <= '0;
            lane_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            asm_q    <= asm_d;
            lane_q   <= lane_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; written on the edge that accepts a word's final byte.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                cnt_mem[i]  <= '0;
                last_mem[i] <= 1'b0;
            end
        end else if (push && !i_clear) begin
            data_mem[wr_ptr_q] <= word;
            cnt_mem[wr_ptr_q]  <= word_cnt;
            last_mem[wr_ptr_q] <= i_transfer_last;
        end
    end

    // First-word-fall-through head; outputs forced to 0 while empty.
    always_comb begin
        o_valid    = (level_q != '0);
        o_level    = level_q;
        o_overflow = ovf_q;
        o_data     = '0;
        o_count    = '0;
        o_last     = 1'b0;
        if (o_valid) begin
            o_data  = data_mem[rd_ptr_q];
            o_count = cnt_mem[rd_ptr_q];
            o_last  = last_mem[rd_ptr_q];
        end
    end

endmodule
